// File: rtl/bus_pkg.sv
// Shared types and helpers for the arbitrated shared data bus.
// Holds the ownership state encoding and the index-width helper.
package bus_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    OWNED = 1'b1
  } state_t;

  // Index width for n entries; never narrower than one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/shared_bus_arbiter_rr_pick.sv
// Round-robin picker: first set mask bit after ptr, wrapping modulo N_SRC.
// Purely combinational (zero latency); no flow control of its own.
module rr_pick
  import bus_pkg::*;
#(
  parameter  int N_SRC = 10,
  localparam int IDX_W = idx_width(N_SRC)
) (
  input  logic [N_SRC-1:0] mask,
  input  logic [IDX_W-1:0] ptr,
  output logic             found,
  output logic [IDX_W-1:0] idx,
  output logic [N_SRC-1:0] onehot
);

  int cand;

  always_comb begin
    found = 1'b0;
    idx   = '0;
    cand  = 0;
    // Scan ptr+1 .. ptr+N_SRC so ptr itself has the lowest priority.
    for (int k = 1; k <= N_SRC; k++) begin
      cand = (int'(ptr) + k) % N_SRC;
      if (!found && mask[cand]) begin
        found = 1'b1;
        idx   = IDX_W'(cand);
      end
    end
    onehot = found ? (N_SRC'(1) << idx) : '0;
  end

endmodule

// File: rtl/shared_bus_arbiter.sv
// Round-robin arbitrated shared bus; owner word registered onto bus, 1-cycle latency.
// No backpressure: requesters hold req until granted; owners are forced off after MAX_HOLD unless locked.
module shared_bus_arbiter
  import bus_pkg::*;
#(
  parameter  int WIDTH    = 16,
  parameter  int N_SRC    = 10,
  parameter  int MAX_HOLD = 4,
  localparam int IDX_W    = idx_width(N_SRC),
  localparam int HC_W     = idx_width(MAX_HOLD + 1)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_SRC-1:0]       req,
  input  logic [N_SRC-1:0]       lock,
  input  logic [N_SRC*WIDTH-1:0] src_data,
  output logic [WIDTH-1:0]       bus,
  output logic                   bus_valid,
  output logic [N_SRC-1:0]       grant,
  output logic [IDX_W-1:0]       grant_idx,
  output logic [HC_W-1:0]        hold_cnt
);

  localparam logic [HC_W-1:0]  HOLD_MAX = HC_W'(MAX_HOLD);
  localparam logic [IDX_W-1:0] PTR_RST  = IDX_W'(N_SRC - 1);

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   rr_ptr, ptr_d;
  logic [N_SRC-1:0]   grant_d;
  logic [IDX_W-1:0]   idx_d;
  logic [WIDTH-1:0]   bus_d;
  logic               valid_d;
  logic [HC_W-1:0]    hold_d;
  logic               take_new;

  logic [N_SRC-1:0]   cand_mask;
  logic               pick_found;
  logic [IDX_W-1:0]   pick_idx;
  logic [N_SRC-1:0]   pick_onehot;

  logic [WIDTH-1:0]   src_word [N_SRC];

  for (genvar i = 0; i < N_SRC; i++) begin : g_unpack
    assign src_word[i] = src_data[i*WIDTH +: WIDTH];
  end

  // While owned, the owner is never a candidate: covers both release and forced handover.
  assign cand_mask = (state_q == IDLE) ? req : (req & ~grant);

  rr_pick #(
    .N_SRC (N_SRC)
  ) u_rr_pick (
    .mask   (cand_mask),
    .ptr    (rr_ptr),
    .found  (pick_found),
    .idx    (pick_idx),
    .onehot (pick_onehot)
  );

  always_comb begin
    state_d  = state_q;
    grant_d  = grant;
    idx_d    = grant_idx;
    bus_d    = bus;
    valid_d  = bus_valid;
    hold_d   = hold_cnt;
    ptr_d    = rr_ptr;
    take_new = 1'b0;

    case (state_q)
      IDLE: begin
        valid_d = 1'b0;
        if (pick_found) take_new = 1'b1;
      end
      OWNED: begin
        if (!req[grant_idx]) begin
          if (pick_found) begin
            take_new = 1'b1;
          end else begin
            state_d = IDLE;
            grant_d = '0;
            valid_d = 1'b0;
            hold_d  = '0;
          end
        end else if (lock[grant_idx] || (hold_cnt < HOLD_MAX)) begin
          bus_d = src_word[grant_idx];
          if (hold_cnt < HOLD_MAX) hold_d = hold_cnt + 1'b1;
        end else if (pick_found) begin
          take_new = 1'b1;
        end else begin
          // Nobody waiting: the owner keeps the bus with the counter pinned.
          bus_d = src_word[grant_idx];
        end
      end
      default: state_d = IDLE;
    endcase

    if (take_new) begin
      state_d = OWNED;
      grant_d = pick_onehot;
      idx_d   = pick_idx;
      bus_d   = src_word[pick_idx];
      valid_d = 1'b1;
      hold_d  = HC_W'(1);
      ptr_d   = pick_idx;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      grant     <= '0;
      grant_idx <= '0;
      bus       <= '0;
      bus_valid <= 1'b0;
      hold_cnt  <= '0;
      rr_ptr    <= PTR_RST;
    end else begin
      state_q   <= state_d;
      grant     <= grant_d;
      grant_idx <= idx_d;
      bus       <= bus_d;
      bus_valid <= valid_d;
      hold_cnt  <= hold_d;
      rr_ptr    <= ptr_d;
    end
  end

endmodule

// File: tb/tb_shared_bus_arbiter.sv
// Self-checking bench for shared_bus_arbiter: reference model feeding a scoreboard,
// a vector table for the two-source rotation, and directed multi-cycle sequences.
module tb_shared_bus_arbiter;

  localparam int WIDTH = 16;
  localparam int N     = 10;
  localparam int MH    = 4;
  localparam int IW    = 4;
  localparam int HW    = 3;

  logic               clk = 1'b0;
  logic               rst;
  logic [N-1:0]       req, lock;
  logic [N*WIDTH-1:0] src_data;
  logic [WIDTH-1:0]   bus;
  logic               bus_valid;
  logic [N-1:0]       grant;
  logic [IW-1:0]      grant_idx;
  logic [HW-1:0]      hold_cnt;

  shared_bus_arbiter #(.WIDTH(WIDTH), .N_SRC(N), .MAX_HOLD(MH)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .lock      (lock),
    .src_data  (src_data),
    .bus       (bus),
    .bus_valid (bus_valid),
    .grant     (grant),
    .grant_idx (grant_idx),
    .hold_cnt  (hold_cnt)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [N-1:0]     grant;
    logic [IW-1:0]    idx;
    logic [WIDTH-1:0] bus;
    logic             valid;
    logic [HW-1:0]    hold;
  } exp_t;

  typedef struct {
    logic [N-1:0] req;
    logic [N-1:0] lock;
    int           exp_idx;
    logic         exp_valid;
    int           exp_hold;
  } vec_t;

  exp_t sb[$];
  vec_t vecs[12];

  // Reference model state
  logic             m_valid;
  int               m_idx, m_ptr, m_hold;
  logic [N-1:0]     m_grant;
  logic [WIDTH-1:0] m_bus;

  logic [N*WIDTH-1:0] cur_data;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int pick(input logic [N-1:0] m, input int p);
    for (int k = 1; k <= N; k++)
      if (m[(p + k) % N]) return (p + k) % N;
    return -1;
  endfunction

  function automatic logic [WIDTH-1:0] word(input logic [N*WIDTH-1:0] d, input int i);
    return d[i*WIDTH +: WIDTH];
  endfunction

  function automatic logic [N*WIDTH-1:0] rnd_data();
    logic [N*WIDTH-1:0] d;
    for (int i = 0; i < N; i++) d[i*WIDTH +: WIDTH] = WIDTH'($urandom);
    return d;
  endfunction

  task automatic model_own(input int w, input logic [N*WIDTH-1:0] d);
    m_idx   = w;
    m_ptr   = w;
    m_grant = N'(1) << w;
    m_bus   = word(d, w);
    m_valid = 1'b1;
    m_hold  = 1;
  endtask

  task automatic model_step(input logic r, input logic [N-1:0] rq, input logic [N-1:0] lk,
                            input logic [N*WIDTH-1:0] d);
    logic [N-1:0] others;
    if (r) begin
      m_valid = 1'b0; m_idx = 0; m_ptr = N - 1; m_hold = 0; m_grant = '0; m_bus = '0;
    end else if (!m_valid) begin
      if (rq != 0) model_own(pick(rq, m_ptr), d);
    end else begin
      others = rq & ~(N'(1) << m_idx);
      if (!rq[m_idx]) begin
        if (others != 0) model_own(pick(others, m_ptr), d);
        else begin m_valid = 1'b0; m_grant = '0; m_hold = 0; end
      end else if (lk[m_idx] || m_hold < MH) begin
        m_bus = word(d, m_idx);
        if (m_hold < MH) m_hold++;
      end else if (others != 0) begin
        model_own(pick(others, m_ptr), d);
      end else begin
        m_bus = word(d, m_idx);
      end
    end
  endtask

  // One clock: drive inputs, push the model's expectation, compare after the edge.
  task automatic cycle(input logic r, input logic [N-1:0] rq, input logic [N-1:0] lk,
                       input logic [N*WIDTH-1:0] d);
    exp_t e;
    rst = r; req = rq; lock = lk; src_data = d; cur_data = d;
    model_step(r, rq, lk, d);
    e.grant = m_grant; e.idx = IW'(m_idx); e.bus = m_bus; e.valid = m_valid; e.hold = HW'(m_hold);
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      checks++; failures++;
      $display("FAIL scoreboard: got empty queue expected one entry");
    end else begin
      e = sb.pop_front();
      check("grant", 32'(grant), 32'(e.grant));
      check("bus_valid", 32'(bus_valid), 32'(e.valid));
      check("bus", 32'(bus), 32'(e.bus));
      check("hold_cnt", 32'(hold_cnt), 32'(e.hold));
      if (e.valid) check("grant_idx", 32'(grant_idx), 32'(e.idx));
      check("grant_onehot0", 32'($onehot0(grant)), 32'd1);
    end
  endtask

  task automatic do_reset();
    cycle(1'b1, '0, '0, rnd_data());
  endtask

  logic [WIDTH-1:0]   last_word;
  logic [N*WIDTH-1:0] d0;

  initial begin
    rst = 1'b1; req = '0; lock = '0; src_data = '0;
    m_valid = 0; m_idx = 0; m_ptr = N - 1; m_hold = 0; m_grant = '0; m_bus = '0;

    // Two-source rotation: owner 2 for MAX_HOLD, then 5, then 2 again, then release.
    for (int i = 0; i < 10; i++) begin
      vecs[i].req       = 10'b0000100100;
      vecs[i].lock      = '0;
      vecs[i].exp_valid = 1'b1;
      vecs[i].exp_idx   = ((i / 4) % 2 == 0) ? 2 : 5;
      vecs[i].exp_hold  = (i % 4) + 1;
    end
    vecs[10] = '{req: '0, lock: '0, exp_idx: 0, exp_valid: 1'b0, exp_hold: 0};
    vecs[11] = '{req: 10'b0000000100, lock: 10'b0000100000, exp_idx: 2, exp_valid: 1'b1, exp_hold: 1};

    // Reset state
    do_reset();
    do_reset();
    check("reset_grant", 32'(grant), 32'd0);
    check("reset_bus", 32'(bus), 32'd0);
    check("reset_valid", 32'(bus_valid), 32'd0);
    check("reset_hold", 32'(hold_cnt), 32'd0);

    // First grant goes to source 0 with its word
    d0 = rnd_data();
    d0[0 +: WIDTH] = 16'hA5A5;
    cycle(1'b0, 10'b0000000001, '0, d0);
    check("first_grant", 32'(grant), 32'd1);
    check("first_idx", 32'(grant_idx), 32'd0);
    check("first_bus", 32'(bus), 32'hA5A5);
    check("first_valid", 32'(bus_valid), 32'd1);
    check("first_hold", 32'(hold_cnt), 32'd1);

    // Vector table
    do_reset();
    for (int i = 0; i < 12; i++) begin
      cycle(1'b0, vecs[i].req, vecs[i].lock, rnd_data());
      check("vec_valid", 32'(bus_valid), 32'(vecs[i].exp_valid));
      check("vec_hold", 32'(hold_cnt), 32'(vecs[i].exp_hold));
      if (vecs[i].exp_valid) check("vec_idx", 32'(grant_idx), 32'(vecs[i].exp_idx));
    end

    // Locked owner 3 keeps the bus past MAX_HOLD while 4 waits
    do_reset();
    cycle(1'b0, 10'b0000001000, '0, rnd_data());
    for (int k = 0; k < 10; k++) begin
      cycle(1'b0, 10'b0000011000, 10'b0000001000, rnd_data());
      check("lock_grant", 32'(grant), 32'h8);
      check("lock_hold", 32'(hold_cnt), 32'((k + 2 > MH) ? MH : k + 2));
    end
    cycle(1'b0, 10'b0000011000, '0, rnd_data());
    check("unlock_handover", 32'(grant_idx), 32'd4);
    check("unlock_valid", 32'(bus_valid), 32'd1);

    // Sole requester 7 is never forced off; release keeps the last word
    do_reset();
    for (int k = 0; k < 20; k++) begin
      cycle(1'b0, 10'b0010000000, '0, rnd_data());
      check("sole_idx", 32'(grant_idx), 32'd7);
      check("sole_hold", 32'(hold_cnt), 32'((k + 1 > MH) ? MH : k + 1));
    end
    last_word = word(cur_data, 7);
    cycle(1'b0, '0, '0, rnd_data());
    check("sole_release_valid", 32'(bus_valid), 32'd0);
    check("sole_release_bus", 32'(bus), 32'(last_word));

    // Everyone requesting: strict rotation 0..9,0 with MAX_HOLD each
    do_reset();
    for (int k = 0; k < (N + 1) * MH; k++) begin
      cycle(1'b0, '1, '0, rnd_data());
      check("all_idx", 32'(grant_idx), 32'((k / MH) % N));
    end

    // Reset during locked ownership of source 6
    do_reset();
    for (int k = 0; k < 3; k++) begin
      cycle(1'b0, 10'b0001000000, 10'b0001000000, rnd_data());
      check("pre_rst_idx", 32'(grant_idx), 32'd6);
    end
    cycle(1'b1, '1, '1, rnd_data());
    check("midrst_grant", 32'(grant), 32'd0);
    check("midrst_bus", 32'(bus), 32'd0);
    check("midrst_valid", 32'(bus_valid), 32'd0);
    cycle(1'b0, '1, '0, rnd_data());
    check("post_rst_idx", 32'(grant_idx), 32'd0);
    check("post_rst_valid", 32'(bus_valid), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
